// File: rtl/layer1_store_ctrl.sv
// layer1_store_ctrl: write-side controller for the layer1 data buffer.
// Packs LANES consecutive DW-bit results into one SRAM word and writes it
// on port A at consecutive (wrapping) addresses from a programmable base.
// Optional build macro: LAYER1_STORE_RELU_EN (negative results stored as 0).
module layer1_store_ctrl #(
  parameter int DEPTH = 912,
  parameter int AW    = 10,
  parameter int LANES = 8,
  parameter int DW    = 16
) (
  input  logic                 CK,
  input  logic                 RSTN,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW-1:0]        word_count,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic [AW-1:0]        sram_A,
  output logic [LANES*DW-1:0]  sram_DIA,
  output logic                 sram_WEAN,
  output logic                 sram_OEA,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = LANES * DW;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DEPTH_W   = AW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lane_cnt_q, lane_cnt_d;
  logic [AW-1:0]   word_idx_q, word_idx_d;
  logic [AW-1:0]   word_cnt_q, word_cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [PW-1:0]   pack_q, pack_d;
  logic [AW-1:0]   sram_a_q, sram_a_d;
  logic [PW-1:0]   sram_dia_q, sram_dia_d;
  logic            sram_wean_q, sram_wean_d;
  logic            err_q, err_d;

  logic            last_strobe;
  logic            ready_c;
  logic            accept;
  logic            have_partial;
  logic [AW-1:0]   addr_nx;
  logic [PW-1:0]   pack_ins;
  logic [PW-1:0]   fill;

  // Value written into a lane; optionally clamps negative results to zero.
  function automatic logic [DW-1:0] store_val(input logic signed [DW-1:0] v);
`ifdef LAYER1_STORE_RELU_EN
    store_val = (v < 0) ? '0 : v;
`else
    store_val = v;
`endif
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    next_addr = (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // A zero word count requests a full-buffer frame.
  function automatic logic [AW-1:0] frame_len(input logic [AW-1:0] wc);
    frame_len = (wc == '0) ? DEPTH_W : wc;
  endfunction

  // Next-state, packing, strobe scheduling and counter updates.
  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    word_idx_d  = word_idx_q;
    word_cnt_d  = word_cnt_q;
    addr_d      = addr_q;
    pack_d      = pack_q;
    sram_a_d    = sram_a_q;
    sram_dia_d  = sram_dia_q;
    sram_wean_d = 1'b1;
    err_d       = err_q;

    // The strobe for the final word closes the input in the same cycle.
    last_strobe = !sram_wean_q && (word_idx_q == word_cnt_q - 1'b1);
    ready_c     = (state_q == S_RUN) && (word_idx_q < word_cnt_q) && !last_strobe;
    accept      = in_valid && ready_c;

    // Address of the word currently being packed, already past any live strobe.
    addr_nx = sram_wean_q ? addr_q : next_addr(addr_q);

    pack_ins = pack_q;
    pack_ins[int'(lane_cnt_q)*DW +: DW] = store_val(in_data);
    fill         = accept ? pack_ins : pack_q;
    have_partial = accept || (lane_cnt_q != '0);

    if (!sram_wean_q) begin
      addr_d     = next_addr(addr_q);
      word_idx_d = word_idx_q + 1'b1;
    end

    case (state_q)
      S_RUN: begin
        if (last_strobe) begin
          state_d = S_DONE;
        end else if (flush) begin
          // Accepted result (if any) joins the word before it is flushed.
          if (have_partial) begin
            sram_wean_d = 1'b0;
            sram_a_d    = addr_nx;
            sram_dia_d  = fill;
            state_d     = S_FLUSH;
          end else begin
            state_d = S_DONE;
          end
          lane_cnt_d = '0;
          pack_d     = '0;
        end else if (accept) begin
          if (lane_cnt_q == LAST_LANE) begin
            sram_wean_d = 1'b0;
            sram_a_d    = addr_nx;
            sram_dia_d  = pack_ins;
            lane_cnt_d  = '0;
            pack_d      = '0;
          end else begin
            pack_d     = pack_ins;
            lane_cnt_d = lane_cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new frame overrides everything; an in-flight partial word is dropped.
    if (start) begin
      state_d     = S_RUN;
      lane_cnt_d  = '0;
      word_idx_d  = '0;
      word_cnt_d  = frame_len(word_count);
      addr_d      = base_addr;
      pack_d      = '0;
      sram_wean_d = 1'b1;
      if ((state_q == S_RUN) || (state_q == S_FLUSH)) begin
        err_d = 1'b1;
      end
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      lane_cnt_q  <= '0;
      word_idx_q  <= '0;
      word_cnt_q  <= '0;
      addr_q      <= '0;
      pack_q      <= '0;
      sram_a_q    <= '0;
      sram_dia_q  <= '0;
      sram_wean_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      word_idx_q  <= word_idx_d;
      word_cnt_q  <= word_cnt_d;
      addr_q      <= addr_d;
      pack_q      <= pack_d;
      sram_a_q    <= sram_a_d;
      sram_dia_q  <= sram_dia_d;
      sram_wean_q <= sram_wean_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = ready_c;
  assign sram_A    = sram_a_q;
  assign sram_DIA  = sram_dia_q;
  assign sram_WEAN = sram_wean_q;
  assign sram_OEA  = 1'b0;
  assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_layer1_store_ctrl.sv
// Self-checking bench for layer1_store_ctrl: directed frames with random data,
// checked against a word-level model of the packed buffer contents.
module tb_layer1_store_ctrl;

  localparam int DEPTH = 912;
  localparam int AW    = 10;
  localparam int LANES = 8;
  localparam int DW    = 16;
  localparam int PW    = LANES * DW;

  logic           CK = 1'b0;
  logic           RSTN = 1'b1;
  logic           start = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic [AW-1:0]  word_count = '0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [DW-1:0]  in_data = '0;
  logic [AW-1:0]  sram_A;
  logic [PW-1:0]  sram_DIA;
  logic           sram_WEAN;
  logic           sram_OEA;
  logic           busy;
  logic           done;
  logic           err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int stalls = 0;
  int viol = 0;

  int            wa_q[$];
  int            wc_q[$];
  logic [PW-1:0] wd_q[$];
  logic [15:0]   acc_q[$];
  logic          prev_low = 1'b0;
  logic [AW-1:0] prev_a = '0;

  layer1_store_ctrl #(.DEPTH(DEPTH), .AW(AW), .LANES(LANES), .DW(DW)) dut (
    .CK(CK), .RSTN(RSTN), .start(start), .base_addr(base_addr),
    .word_count(word_count), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .sram_A(sram_A),
    .sram_DIA(sram_DIA), .sram_WEAN(sram_WEAN), .sram_OEA(sram_OEA),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CK = ~CK;

  always @(posedge CK) cyc <= cyc + 1;

  // Strobe recorder, sampled mid-cycle.
  always @(negedge CK) begin
    if (RSTN && !sram_WEAN) begin
      wa_q.push_back(int'(sram_A));
      wd_q.push_back(sram_DIA);
      wc_q.push_back(cyc);
      if (prev_low && (prev_a == sram_A)) viol = viol + 1;
    end
    prev_low = RSTN && !sram_WEAN;
    prev_a   = sram_A;
  end

  function automatic logic [15:0] ref_store(input logic [15:0] v);
`ifdef LAYER1_STORE_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge CK);
    #1;
  endtask

  task automatic do_start(input int base, input int cnt);
    wa_q.delete(); wd_q.delete(); wc_q.delete(); acc_q.delete();
    base_addr = AW'(base);
    word_count = AW'(cnt);
    start = 1'b1;
    clk1();
    start = 1'b0;
  endtask

  // Offer one value, optionally after random idle cycles; leaves in_valid high.
  task automatic push(input logic [15:0] v, input int max_gap);
    int g;
    bit ok;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    if (g > 0) begin
      in_valid = 1'b0;
      repeat (g) clk1();
    end
    in_valid = 1'b1;
    in_data = v;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge CK);
      if (in_ready) begin
        @(posedge CK); #1;
        ok = 1'b1;
      end else begin
        stalls++;
        @(posedge CK); #1;
      end
    end
    if (ok) acc_q.push_back(v);
    chki("push_accepted", int'(ok), 1);
  endtask

  // Returns while done is high, or after a bounded wait.
  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!done && t < 60) begin
      clk1();
      t++;
    end
    chki(tag, int'(done), 1);
  endtask

  // Expected buffer image: accepted values grouped LANES per word, zero padded,
  // at consecutive addresses modulo DEPTH from the frame base.
  task automatic check_frame(input string tag, input int base, input int nw);
    logic [PW-1:0] d;
    chki($sformatf("%s_nstrobes", tag), wa_q.size(), nw);
    for (int k = 0; k < nw && k < wa_q.size(); k++) begin
      d = '0;
      for (int i = 0; i < LANES; i++)
        if (k * LANES + i < acc_q.size())
          d = d | (PW'(ref_store(acc_q[k * LANES + i])) << (DW * i));
      chki($sformatf("%s_addr%0d", tag, k), wa_q[k], (base + k) % DEPTH);
      chk($sformatf("%s_data%0d", tag, k), wd_q[k], d);
    end
  endtask

  initial begin
    logic [PW-1:0] full_exp;
    logic [PW-1:0] flush_exp;
    logic [15:0]   relu_l0;
    int b;

    full_exp  = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    flush_exp = 128'h0000_0000_0000_0000_0000_AAAA_AAAA_AAAA;

    // Reset values
    #1 RSTN = 1'b0;
    repeat (2) clk1();
    chki("rst_in_ready", int'(in_ready), 0);
    chki("rst_sram_A", int'(sram_A), 0);
    chk("rst_sram_DIA", sram_DIA, '0);
    chki("rst_sram_WEAN", int'(sram_WEAN), 1);
    chki("rst_sram_OEA", int'(sram_OEA), 0);
    chki("rst_busy", int'(busy), 0);
    chki("rst_done", int'(done), 0);
    chki("rst_err", int'(err), 0);
    RSTN = 1'b1;
    clk1();

    // Single full word
    do_start(0, 1);
    chki("full_busy", int'(busy), 1);
    for (int i = 1; i <= 8; i++) push(16'(i), 0);
    in_valid = 1'b0;
    chki("full_ready_low", int'(in_ready), 0);
    wait_done("full_done");
    check_frame("full", 0, 1);
    if (wd_q.size() > 0) chk("full_literal", wd_q[0], full_exp);
    if (wc_q.size() > 0) chki("full_done_cycle", cyc, wc_q[0] + 1);
    clk1();
    chki("full_done_pulse", int'(done), 0);
    chki("full_err", int'(err), 0);

    // Throughput across the address wrap
    do_start(910, 3);
    stalls = 0;
    for (int i = 0; i < 24; i++) push(16'($urandom), 0);
    in_valid = 1'b0;
    wait_done("wrap_done");
    check_frame("wrap", 910, 3);
    chki("wrap_stalls", stalls, 0);
    if (wc_q.size() == 3) begin
      chki("wrap_gap1", wc_q[1] - wc_q[0], 8);
      chki("wrap_gap2", wc_q[2] - wc_q[1], 8);
    end
    clk1();

    // Flush of a partial word
    do_start(100, 4);
    for (int i = 0; i < 3; i++) push(16'hAAAA, 0);
    in_valid = 1'b0;
    flush = 1'b1;
    clk1();
    flush = 1'b0;
    wait_done("flush_done");
    repeat (10) clk1();
    check_frame("flush", 100, 1);
    if (wd_q.size() > 0) chk("flush_literal", wd_q[0], flush_exp);

    // Flush with nothing packed: straight to done, no write
    do_start(50, 2);
    flush = 1'b1;
    clk1();
    flush = 1'b0;
    wait_done("flush0_done");
    chki("flush0_nstrobes", wa_q.size(), 0);

    // Restart issued during DONE, then backpressured input
    b = int'($urandom_range(DEPTH - 1, 0));
    do_start(b, 2);
    chki("restart_err", int'(err), 0);
    chki("restart_busy", int'(busy), 1);
    for (int i = 0; i < 16; i++) push(16'($urandom), 3);
    in_valid = 1'b0;
    wait_done("bp_done");
    check_frame("bp", b, 2);
    clk1();

    // Lane clamping for negative results
    do_start(5, 1);
    push(16'h8001, 0); push(16'h7FFF, 0); push(16'hFFFF, 0);
    for (int i = 0; i < 5; i++) push(16'h0000, 0);
    in_valid = 1'b0;
    wait_done("relu_done");
    check_frame("relu", 5, 1);
`ifdef LAYER1_STORE_RELU_EN
    relu_l0 = 16'h0000;
`else
    relu_l0 = 16'h8001;
`endif
    if (wd_q.size() > 0) begin
      chk("relu_lane0", PW'(wd_q[0][15:0]), PW'(relu_l0));
      chk("relu_lane1", PW'(wd_q[0][31:16]), PW'(16'h7FFF));
    end
    clk1();

    // Abort a frame by a second start
    do_start(400, 3);
    for (int i = 0; i < 5; i++) push(16'($urandom), 0);
    in_valid = 1'b0;
    clk1();
    chki("abort_no_partial", wa_q.size(), 0);
    do_start(700, 1);
    chki("abort_err", int'(err), 1);
    for (int i = 0; i < 8; i++) push(16'($urandom), 1);
    in_valid = 1'b0;
    wait_done("abort_done");
    check_frame("abort", 700, 1);
    clk1();
    chki("abort_err_sticky", int'(err), 1);

    // Reset in the middle of a frame
    do_start(300, 2);
    for (int i = 0; i < 7; i++) push(16'($urandom), 0);
    in_data = 16'h1234;
    #2 RSTN = 1'b0;
    repeat (3) clk1();
    chki("midrst_nstrobes", wa_q.size(), 0);
    chki("midrst_busy", int'(busy), 0);
    chki("midrst_wean", int'(sram_WEAN), 1);
    chki("midrst_ready", int'(in_ready), 0);
    chki("midrst_err", int'(err), 0);
    in_valid = 1'b0;
    RSTN = 1'b1;
    repeat (3) clk1();
    chki("midrst_after", wa_q.size(), 0);

    chki("no_repeat_strobe", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
